// File: rtl/vic_bus_if.sv
// CPU-side register bus of the VIC: strobe, select, direction, index and data.
interface vic_bus_if;
    logic       cpu_en;
    logic       cs;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cpu_en, cs, we, addr, din, input dout);
    modport slave  (input cpu_en, cs, we, addr, din, output dout);
endinterface

// File: rtl/vic_regs.sv
// VIC 6560/6561 register file: CPU decode, 16 registers, staged video configuration,
// live sound registers and read-back of raster/pot values.
module vic_regs #(
    parameter bit LATCH_AT_FRAME = 1'b1,
    parameter bit NTSC           = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    vic_bus_if.slave    bus,
    input  logic [8:0]  raster_line,
    input  logic        frame_start,
    input  logic [7:0]  pot_x,
    input  logic [7:0]  pot_y,
    output logic [15:0] screen_addr,
    output logic [15:0] char_rom_addr,
    output logic [15:0] color_ram_addr,
    output logic [2:0]  border_color,
    output logic [3:0]  back_color,
    output logic [3:0]  aux_color,
    output logic        inverted,
    output logic        chars8x16,
    output logic [6:0]  rows,
    output logic [6:0]  cols,
    output logic [6:0]  h_origin,
    output logic [7:0]  v_origin,
    output logic        interlace,
    output logic [7:0]  snd_voice0,
    output logic [7:0]  snd_voice1,
    output logic [7:0]  snd_voice2,
    output logic [7:0]  snd_noise,
    output logic [3:0]  snd_volume
);
    localparam logic [7:0] R0_RST = NTSC ? 8'h05 : 8'h0C;
    localparam logic [15:0][7:0] REG_RST = {
        8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hF0, 8'h00, 8'hAE, 8'h96, 8'h26, R0_RST};

    // Only the register bits the video stage consumes are staged.
    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [6:0] r3;
        logic [7:0] r5;
        logic [3:0] aux;
        logic [7:0] r15;
    } vid_cfg_t;

    logic [15:0][7:0] regs, regs_nxt;
    logic [7:0]       rd_val;
    logic             wr_en, rd_en, wr_ok;
    vid_cfg_t         cfg_now, cfg;
    logic [13:0]      screen_va, char_va;

    assign wr_en = bus.cpu_en & bus.cs & bus.we;
    assign rd_en = bus.cpu_en & bus.cs & ~bus.we;
    assign wr_ok = !(bus.addr == 4'h4 || (bus.addr >= 4'h6 && bus.addr <= 4'h9));

    always_comb begin
        regs_nxt = regs;
        if (wr_en && wr_ok) regs_nxt[bus.addr] = bus.din;
    end

    always_comb begin
        rd_val = regs[bus.addr];
        case (bus.addr)
            4'h3:       rd_val = {raster_line[0], regs[3][6:0]};
            4'h4:       rd_val = raster_line[8:1];
            4'h6, 4'h7: rd_val = 8'h00;
            4'h8:       rd_val = pot_x;
            4'h9:       rd_val = pot_y;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs     <= REG_RST;
            bus.dout <= 8'h00;
        end else begin
            regs <= regs_nxt;
            if (rd_en) bus.dout <= rd_val;
        end
    end

    assign cfg_now = '{r0: regs[0], r1: regs[1], r2: regs[2], r3: regs[3][6:0],
                       r5: regs[5], aux: regs[14][7:4], r15: regs[15]};

    generate
        if (LATCH_AT_FRAME) begin : g_latch
            // Sampled from the pre-write registers, so a same-cycle write waits a frame.
            vid_cfg_t shadow;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    shadow <= '{r0: R0_RST, r1: 8'h26, r2: 8'h96, r3: 7'h2E,
                                r5: 8'hF0, aux: 4'h0, r15: 8'h1B};
                else if (frame_start)
                    shadow <= cfg_now;
            end
            assign cfg = shadow;
        end else begin : g_direct
            assign cfg = cfg_now;
        end
    endgenerate

    // VIC 14-bit address to CPU: A13 inverted lands in $8000, else in $0000-$1FFF.
    assign screen_va      = {cfg.r5[7:4], cfg.r2[7], 9'b0};
    assign char_va        = {cfg.r5[3:0], 10'b0};
    assign screen_addr    = {~screen_va[13], 2'b00, screen_va[12:0]};
    assign char_rom_addr  = {~char_va[13], 2'b00, char_va[12:0]};
    assign color_ram_addr = 16'h9400 | {6'b0, cfg.r2[7], 9'b0};

    assign h_origin     = cfg.r0[6:0];
    assign interlace    = cfg.r0[7];
    assign v_origin     = cfg.r1;
    assign cols         = cfg.r2[6:0];
    assign rows         = {1'b0, cfg.r3[6:1]};
    assign chars8x16    = cfg.r3[0];
    assign aux_color    = cfg.aux;
    assign border_color = cfg.r15[2:0];
    assign inverted     = cfg.r15[3];
    assign back_color   = cfg.r15[7:4];

    assign snd_voice0 = regs[10];
    assign snd_voice1 = regs[11];
    assign snd_voice2 = regs[12];
    assign snd_noise  = regs[13];
    assign snd_volume = regs[14][3:0];
endmodule

// File: tb/tb_vic_regs.sv
// Randomized and directed check of vic_regs against a register-level reference model.
module tb_vic_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  raster_line = '0;
    logic        frame_start = 1'b0;
    logic [7:0]  pot_x = '0, pot_y = '0;
    logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
    logic [2:0]  border_color;
    logic [3:0]  back_color, aux_color, snd_volume;
    logic        inverted, chars8x16, interlace;
    logic [6:0]  rows, cols, h_origin;
    logic [7:0]  v_origin, snd_voice0, snd_voice1, snd_voice2, snd_noise;

    vic_bus_if bus ();

    vic_regs #(.LATCH_AT_FRAME(1'b1), .NTSC(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .raster_line(raster_line), .frame_start(frame_start),
        .pot_x(pot_x), .pot_y(pot_y),
        .screen_addr(screen_addr), .char_rom_addr(char_rom_addr),
        .color_ram_addr(color_ram_addr), .border_color(border_color),
        .back_color(back_color), .aux_color(aux_color), .inverted(inverted),
        .chars8x16(chars8x16), .rows(rows), .cols(cols), .h_origin(h_origin),
        .v_origin(v_origin), .interlace(interlace),
        .snd_voice0(snd_voice0), .snd_voice1(snd_voice1), .snd_voice2(snd_voice2),
        .snd_noise(snd_noise), .snd_volume(snd_volume)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int m_reg [16];
    int m_sh  [16];
    int m_dout;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_reg[0] = 'h0C; m_reg[1] = 'h26; m_reg[2] = 'h96; m_reg[3] = 'hAE;
        m_reg[5] = 'hF0; m_reg[15] = 'h1B;
        for (int i = 0; i < 16; i++) m_sh[i] = m_reg[i];
        m_dout = 0;
    endfunction

    function automatic int to_cpu(input int va);
        return (va >= 8192) ? va - 8192 : va + 32768;
    endfunction

    function automatic int m_read(input int a);
        case (a)
            3:       return (raster_line % 2) * 128 + m_reg[3] % 128;
            4:       return raster_line / 2;
            6, 7:    return 0;
            8:       return pot_x;
            9:       return pot_y;
            default: return m_reg[a];
        endcase
    endfunction

    task automatic check_all();
        chk("dout",      bus.dout, m_dout);
        chk("screen",    screen_addr, to_cpu((m_sh[5] / 16) * 1024 + (m_sh[2] / 128) * 512));
        chk("charrom",   char_rom_addr, to_cpu((m_sh[5] % 16) * 1024));
        chk("colram",    color_ram_addr, 'h9400 + (m_sh[2] / 128) * 512);
        chk("border",    border_color, m_sh[15] % 8);
        chk("inverted",  inverted, (m_sh[15] / 8) % 2);
        chk("back",      back_color, m_sh[15] / 16);
        chk("aux",       aux_color, m_sh[14] / 16);
        chk("cols",      cols, m_sh[2] % 128);
        chk("rows",      rows, (m_sh[3] / 2) % 64);
        chk("c8x16",     chars8x16, m_sh[3] % 2);
        chk("horg",      h_origin, m_sh[0] % 128);
        chk("ilace",     interlace, m_sh[0] / 128);
        chk("vorg",      v_origin, m_sh[1]);
        chk("voice0",    snd_voice0, m_reg[10]);
        chk("voice1",    snd_voice1, m_reg[11]);
        chk("voice2",    snd_voice2, m_reg[12]);
        chk("noise",     snd_noise, m_reg[13]);
        chk("volume",    snd_volume, m_reg[14] % 16);
    endtask

    // One bus cycle: drive, let the edge happen, advance the model, then check.
    task automatic step(input bit en, input bit sel, input bit wr, input int a,
                        input int d, input bit fs);
        bus.cpu_en = en; bus.cs = sel; bus.we = wr;
        bus.addr = 4'(a); bus.din = 8'(d); frame_start = fs;
        @(posedge clk);
        if (en && sel && !wr) m_dout = m_read(a);
        if (fs) for (int i = 0; i < 16; i++) m_sh[i] = m_reg[i];
        if (en && sel && wr && !(a == 4 || (a >= 6 && a <= 9))) m_reg[a] = d;
        @(negedge clk);
        check_all();
    endtask

    task automatic wr_reg(input int a, input int d); step(1, 1, 1, a, d, 0); endtask
    task automatic rd_reg(input int a);              step(1, 1, 0, a, 0, 0); endtask
    task automatic frame();                          step(0, 0, 0, 0, 0, 1); endtask

    initial begin
        bus.cpu_en = 0; bus.cs = 0; bus.we = 0; bus.addr = '0; bus.din = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b0;
        chk("rst_screen", screen_addr, 'h1E00);
        chk("rst_char",   char_rom_addr, 'h8000);
        chk("rst_color",  color_ram_addr, 'h9600);
        chk("rst_cols",   cols, 22);
        chk("rst_rows",   rows, 23);
        chk("rst_border", border_color, 3);
        chk("rst_back",   back_color, 1);

        wr_reg(5, 'hCC);
        wr_reg(2, 'h16);
        chk("pre_frame_screen", screen_addr, 'h1E00);
        frame();
        chk("scr_cc",   screen_addr, 'h1000);
        chk("char_cc",  char_rom_addr, 'h1000);
        chk("color_cc", color_ram_addr, 'h9400);

        step(1, 1, 1, 15, 'h08, 1);
        chk("same_cyc_border", border_color, 3);
        chk("same_cyc_back",   back_color, 1);
        frame();
        chk("next_border", border_color, 0);
        chk("next_back",   back_color, 0);
        chk("next_inv",    inverted, 1);

        raster_line = 9'h135;
        rd_reg(4);
        chk("rd_raster", bus.dout, 'h9A);
        wr_reg(3, 'h2E);
        rd_reg(3);
        chk("rd_9003", bus.dout, 'hAE);

        pot_x = 8'h3C;
        wr_reg(4, 'hFF);
        wr_reg(8, 'h55);
        rd_reg(4);
        chk("ro_9004", bus.dout, 'h9A);
        rd_reg(8);
        chk("ro_9008", bus.dout, 'h3C);

        // cpu_en low must not write even with cs/we set
        step(0, 1, 1, 15, 'h77, 0);
        step(0, 1, 0, 8, 0, 0);

        wr_reg(15, 'h00);
        frame();
        chk("pre_rst_border", border_color, 0);
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("async_border", border_color, 3);
        chk("async_back",   back_color, 1);
        chk("async_dout",   bus.dout, 0);
        @(negedge clk);
        reset = 1'b0;
        check_all();

        for (int n = 0; n < 500; n++) begin
            raster_line = 9'($urandom);
            pot_x = 8'($urandom);
            pot_y = 8'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
